// File: rtl/cache_pkg.sv
// Shared constants for the cache tag stage: ceil-log2 helper, default-config
// field widths and the lookup FSM state encodings.
package cache_pkg;

    localparam int ADDR_W = 16;

    function automatic int clog2(input int value);
        int result = 0;
        int remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Widths for the default geometry: 16 ways, 4-byte lines, 64 KiB.
    localparam int DEF_WAY             = 16;
    localparam int DEF_BLOCK_SIZE_BYTE = 4;
    localparam int DEF_CACHE_SIZE_BYTE = 65536;
    localparam int BLOCK_OFFSET_INDEX  = clog2(DEF_BLOCK_SIZE_BYTE);
    localparam int SET_INDEX           = clog2(DEF_CACHE_SIZE_BYTE / (DEF_BLOCK_SIZE_BYTE * DEF_WAY));
    localparam int TAG_W               = ADDR_W - SET_INDEX - BLOCK_OFFSET_INDEX;
    localparam int WAY_W               = (DEF_WAY > 1) ? clog2(DEF_WAY) : 1;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t LOOKUP    = 3'd1;
    localparam state_t MISS_WAIT = 3'd2;
    localparam state_t FILL      = 3'd3;
    localparam state_t RESP      = 3'd4;

endpackage

// File: rtl/victim_select.sv
// Replacement choice for one set: lowest invalid way, else the round-robin
// pointer (and only then does the pointer advance).
module victim_select #(
    parameter int WAY   = 16,
    parameter int WAY_W = 4
) (
    input  logic [WAY-1:0]   valid,
    input  logic [WAY_W-1:0] rr_ptr,
    output logic [WAY_W-1:0] victim,
    output logic             advance_rr
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        victim     = rr_ptr;
        advance_rr = 1'b1;
        for (int w = WAY - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim     = WAY_W'(w);
                advance_rr = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cache_tag_lookup.sv
// Tag stage of the set-associative cache: lookup, miss hand-off to the fill
// stage, victim install. Define CACHE_STATS_EN to add saturating hit/miss counters.
module cache_tag_lookup #(
    parameter int WAY                = 16,
    parameter int BLOCK_SIZE_BYTE    = 4,
    parameter int CACHE_SIZE_BYTE    = 65536,
    parameter int BLOCK_OFFSET_INDEX = cache_pkg::clog2(BLOCK_SIZE_BYTE),
    parameter int SET                = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY),
    parameter int SET_INDEX          = cache_pkg::clog2(SET),
    parameter int TAG_W              = cache_pkg::ADDR_W - SET_INDEX - BLOCK_OFFSET_INDEX,
    parameter int WAY_W              = (WAY > 1) ? cache_pkg::clog2(WAY) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [15:0]                   req_addr,
    output logic                          found_in_cache,
    output logic [TAG_W-1:0]              tag,
    output logic [SET_INDEX-1:0]          index,
    output logic [BLOCK_OFFSET_INDEX-1:0] block_offset,
    input  logic [BLOCK_SIZE_BYTE*8-1:0]  block,
    input  logic                          block_ready,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic                          resp_hit,
    output logic [WAY_W-1:0]              resp_way,
    output logic [BLOCK_SIZE_BYTE*8-1:0]  resp_block
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                   hit_count,
    output logic [31:0]                   miss_count
`endif
);

    cache_pkg::state_t state;

    logic [WAY-1:0]              valid_q  [SET];
    logic [TAG_W-1:0]            tag_mem  [SET][WAY];
    logic [WAY_W-1:0]            rr_ptr   [SET];
    logic [BLOCK_SIZE_BYTE*8-1:0] fill_block;

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic             advance_rr;

    assign req_ready  = (state == cache_pkg::IDLE);
    assign resp_valid = (state == cache_pkg::RESP);

    // Parallel compare of every way in the latched set; lowest matching way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAY - 1; w >= 0; w--) begin
            if (valid_q[index][w] && (tag_mem[index][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    victim_select #(
        .WAY   (WAY),
        .WAY_W (WAY_W)
    ) u_victim_select (
        .valid      (valid_q[index]),
        .rr_ptr     (rr_ptr[index]),
        .victim     (victim),
        .advance_rr (advance_rr)
    );

    // NOTE: the tag array has no reset; valid bits alone decide whether a stored tag means anything.
    always_ff @(posedge clk) begin
        if (state == cache_pkg::FILL) begin
            tag_mem[index][victim] <= tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
        if (!reset) begin
            state          <= cache_pkg::IDLE;
            valid_q        <= '{default: '0};
            rr_ptr         <= '{default: '0};
            found_in_cache <= 1'b1;
            tag            <= '0;
            index          <= '0;
            block_offset   <= '0;
            fill_block     <= '0;
            resp_hit       <= 1'b0;
            resp_way       <= '0;
            resp_block     <= '0;
        end else begin
            case (state)
                cache_pkg::IDLE: begin
                    if (req_valid) begin
                        tag          <= req_addr[cache_pkg::ADDR_W-1 -: TAG_W];
                        index        <= req_addr[BLOCK_OFFSET_INDEX +: SET_INDEX];
                        block_offset <= req_addr[BLOCK_OFFSET_INDEX-1:0];
                        state        <= cache_pkg::LOOKUP;
                    end
                end
                cache_pkg::LOOKUP: begin
                    if (hit) begin
                        resp_hit   <= 1'b1;
                        resp_way   <= hit_way;
                        resp_block <= '0;
                        state      <= cache_pkg::RESP;
                    end else begin
                        found_in_cache <= 1'b0;
                        state          <= cache_pkg::MISS_WAIT;
                    end
                end
                cache_pkg::MISS_WAIT: begin
                    if (block_ready) begin
                        fill_block <= block;
                        state      <= cache_pkg::FILL;
                    end
                end
                cache_pkg::FILL: begin
                    valid_q[index][victim] <= 1'b1;
                    if (advance_rr) begin
                        rr_ptr[index] <= (rr_ptr[index] == WAY_W'(WAY - 1)) ? '0 : rr_ptr[index] + 1'b1;
                    end
                    found_in_cache <= 1'b1;
                    resp_hit       <= 1'b0;
                    resp_way       <= victim;
                    resp_block     <= fill_block;
                    state          <= cache_pkg::RESP;
                end
                cache_pkg::RESP: begin
                    if (resp_ready) begin
                        state <= cache_pkg::IDLE;
                    end
                end
                default: state <= cache_pkg::IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == cache_pkg::LOOKUP) begin
            if (hit) begin
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Self-checking bench for cache_tag_lookup (16 ways, 4-byte lines, 1 KiB so
// that set 0 can hold more distinct tags than it has ways).
module tb_cache_tag_lookup;

    localparam int WAY   = 16;
    localparam int BS    = 4;
    localparam int CS    = 1024;
    localparam int OFF_W = 2;
    localparam int IDX_W = 4;
    localparam int TAG_W = 10;
    localparam int WAY_W = 4;
    localparam int BLK_W = BS * 8;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [15:0]       req_addr;
    logic              found_in_cache;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  index;
    logic [OFF_W-1:0]  block_offset;
    logic [BLK_W-1:0]  block;
    logic              block_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_hit;
    logic [WAY_W-1:0]  resp_way;
    logic [BLK_W-1:0]  resp_block;
`ifdef CACHE_STATS_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
`endif

    cache_tag_lookup #(
        .WAY             (WAY),
        .BLOCK_SIZE_BYTE (BS),
        .CACHE_SIZE_BYTE (CS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .found_in_cache (found_in_cache),
        .tag            (tag),
        .index          (index),
        .block_offset   (block_offset),
        .block          (block),
        .block_ready    (block_ready),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_hit       (resp_hit),
        .resp_way       (resp_way),
        .resp_block     (resp_block)
`ifdef CACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      addr;
        bit               exp_hit;
        logic [WAY_W-1:0] exp_way;
        logic [BLK_W-1:0] blk;
        bit               noise;
        int               hold;
    } vec_t;

    typedef struct {
        bit               hit;
        logic [WAY_W-1:0] way;
        logic [BLK_W-1:0] blk;
    } exp_t;

    vec_t vecs_a[$];
    vec_t vecs_b[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] addr, input bit exp_hit, input int way,
                                input logic [BLK_W-1:0] blk, input bit noise, input int hold);
        vec_t v;
        v.addr    = addr;
        v.exp_hit = exp_hit;
        v.exp_way = WAY_W'(way);
        v.blk     = blk;
        v.noise   = noise;
        v.hold    = hold;
        return v;
    endfunction

    // Drives one request through the DUT; the fill stage is modelled here for misses.
    task automatic run_req(input vec_t v);
        exp_t             e;
        exp_t             got;
        int               gap;
        logic [TAG_W-1:0] et;
        logic [IDX_W-1:0] ei;
        logic [OFF_W-1:0] eo;
        et = v.addr[15:6];
        ei = v.addr[5:2];
        eo = v.addr[1:0];

        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        e.hit = v.exp_hit;
        e.way = v.exp_way;
        e.blk = v.exp_hit ? '0 : v.blk;
        sb.push_back(e);

        @(negedge clk);
        req_valid = 1'b0;
        check("req_ready_busy", req_ready, 0);
        check("latched_fields", {tag, index, block_offset}, {et, ei, eo});
        if (v.noise) begin
            block       = 32'hBADC_0FFE;
            block_ready = 1'b1;
        end

        @(negedge clk);
        block_ready = 1'b0;
        if (!v.exp_hit) begin
            check("found_low", found_in_cache, 0);
            gap = $urandom_range(0, 2);
            for (int i = 0; i < gap; i++) begin
                @(negedge clk);
                check("miss_wait_hold", {found_in_cache, resp_valid, tag, index}, {1'b0, 1'b0, et, ei});
            end
            block       = v.blk;
            block_ready = 1'b1;
            @(negedge clk);
            block_ready = 1'b0;
            block       = '0;
            check("fill_no_resp", resp_valid, 0);
            @(negedge clk);
            check("found_restored", found_in_cache, 1);
        end
        check("resp_valid_latency", resp_valid, 1);

        for (int i = 0; i < v.hold; i++) begin
            req_valid = 1'b1;
            req_addr  = 16'h0F0F;
            @(negedge clk);
            check("hold_stable", {resp_valid, req_ready, resp_way}, {1'b1, 1'b0, e.way});
        end
        req_valid = 1'b0;

        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            got = sb.pop_front();
            check("resp_hit", resp_hit, got.hit);
            check("resp_way", resp_way, got.way);
            check("resp_block", resp_block, got.blk);
        end

        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_drop", {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        block       = '0;
        block_ready = 1'b0;
        resp_ready  = 1'b0;

        // First pass: cold miss/hit, set-0 fill and eviction, top-of-range address.
        vecs_a.push_back(mk(16'h1234, 0, 0, 32'hDEAD_BEEF, 0, 0));
        vecs_a.push_back(mk(16'h1234, 1, 0, '0, 1, 0));
        vecs_a.push_back(mk(16'h1234, 1, 0, '0, 0, 5));
        for (int t = 1; t <= 16; t++) begin
            vecs_a.push_back(mk(16'(t << 6), 0, t - 1, 32'hC0DE_0000 | 32'(t), 0, 0));
        end
        vecs_a.push_back(mk(16'h0440, 0, 0, 32'hC0DE_0011, 0, 0));
        vecs_a.push_back(mk(16'h0040, 0, 1, 32'h1111_0001, 0, 0));
        vecs_a.push_back(mk(16'h00C0, 1, 2, '0, 0, 0));
        vecs_a.push_back(mk(16'h0443, 1, 0, '0, 1, 0));
        vecs_a.push_back(mk(16'h0080, 0, 2, 32'h2222_0002, 0, 0));
        vecs_a.push_back(mk(16'hFFFF, 0, 0, 32'hFFFF_0000, 0, 0));
        vecs_a.push_back(mk(16'hFFFC, 1, 0, '0, 0, 0));

        // After a reset mid-miss everything must be cold again.
        vecs_b.push_back(mk(16'h2468, 0, 0, 32'h2468_2468, 0, 0));
        vecs_b.push_back(mk(16'h1234, 0, 0, 32'h5555_AAAA, 0, 0));
        vecs_b.push_back(mk(16'h1234, 1, 0, '0, 0, 0));

        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_found", found_in_cache, 1);
        check("rst_resp", {resp_valid, resp_hit, resp_way, resp_block}, '0);
        check("rst_fields", {tag, index, block_offset}, '0);
        reset = 1'b1;

        // block_ready while idle must be ignored.
        @(negedge clk);
        block       = 32'hFFFF_FFFF;
        block_ready = 1'b1;
        repeat (2) @(negedge clk);
        block_ready = 1'b0;
        block       = '0;
        check("idle_block_ready_ignored", {req_ready, found_in_cache, resp_valid}, 3'b110);

        foreach (vecs_a[i]) run_req(vecs_a[i]);

        // Reset while waiting for the fill stage.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 16'h2468;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("midmiss_found_low", found_in_cache, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midmiss_rst_found", found_in_cache, 1);
        check("midmiss_rst_ready", req_ready, 1);
        check("midmiss_rst_resp", resp_valid, 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs_b[i]) run_req(vecs_b[i]);

`ifdef CACHE_STATS_EN
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_req(mk(16'h1000, 0, 0, 32'h0000_1000, 0, 0));
        run_req(mk(16'h2000, 0, 1, 32'h0000_2000, 0, 0));
        run_req(mk(16'h3000, 0, 2, 32'h0000_3000, 0, 0));
        run_req(mk(16'h1000, 1, 0, '0, 0, 0));
        run_req(mk(16'h1000, 1, 0, '0, 0, 0));
        check("miss_count", miss_count, 32'd3);
        check("hit_count", hit_count, 32'd2);
        force dut.hit_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.hit_count;
        run_req(mk(16'h2000, 1, 1, '0, 0, 0));
        check("hit_count_saturated", hit_count, 32'hFFFF_FFFF);
        check("miss_count_unchanged", miss_count, 32'd3);
`endif

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
